// File: rtl/simp_isa_pkg.sv
// SIMP ISA definitions shared by the decode stage: opcode encodings,
// decoded class codes, register-select names and the pure opcode decoder.
package simp_isa_pkg;

  // Major opcode encodings (top nibble of the instruction word)
  localparam logic [3:0] OPC_ADD       = 4'b1000;
  localparam logic [3:0] OPC_SHIFT_ROT = 4'b1010;
  localparam logic [3:0] OPC_NANDI     = 4'b1011;
  localparam logic [3:0] OPC_ORI       = 4'b1100;
  localparam logic [3:0] OPC_XORI      = 4'b1101;
  localparam logic [3:0] OPC_LES       = 4'b1110;
  localparam logic [3:0] OPC_LEQ       = 4'b1111;
  localparam logic [3:0] OPC_IGET      = 4'b0100;
  localparam logic [3:0] OPC_MGET      = 4'b0010;
  localparam logic [3:0] OPC_POP       = 4'b0001;
  localparam logic [3:0] OPC_HI        = 4'b0110;
  localparam logic [3:0] OPC_LO        = 4'b0111;

  // Sub-field value that turns the 0001 group into POP_R
  localparam logic [1:0] SUB_POP_R     = 2'b10;

  // Decoded instruction class; CLS_NONE marks an illegal word
  typedef enum logic [3:0] {
    CLS_NONE      = 4'd0,
    CLS_ADD       = 4'd1,
    CLS_SHIFT_ROT = 4'd2,
    CLS_NANDI     = 4'd3,
    CLS_ORI       = 4'd4,
    CLS_XORI      = 4'd5,
    CLS_LES       = 4'd6,
    CLS_LEQ       = 4'd7,
    CLS_IGET      = 4'd8,
    CLS_MGET      = 4'd9,
    CLS_POP_R     = 4'd10,
    CLS_HI_LO     = 4'd11
  } cls_e;

  // Register selector carried in the low two bits
  typedef enum logic [1:0] {
    RSEL_A = 2'd0,
    RSEL_B = 2'd1,
    RSEL_V = 2'd2,
    RSEL_X = 2'd3
  } rsel_e;

  // Map opcode/sub-field to the instruction class
  function automatic cls_e decode_cls(input logic [3:0] opcode, input logic [1:0] sub);
    cls_e cls;
    cls = CLS_NONE;
    case (opcode)
      OPC_ADD:       cls = CLS_ADD;
      OPC_SHIFT_ROT: cls = CLS_SHIFT_ROT;
      OPC_NANDI:     cls = CLS_NANDI;
      OPC_ORI:       cls = CLS_ORI;
      OPC_XORI:      cls = CLS_XORI;
      OPC_LES:       cls = CLS_LES;
      OPC_LEQ:       cls = CLS_LEQ;
      OPC_IGET:      cls = CLS_IGET;
      OPC_MGET:      cls = CLS_MGET;
      OPC_POP: begin
        if (sub == SUB_POP_R) begin
          cls = CLS_POP_R;
        end else begin
          cls = CLS_NONE;
        end
      end
      OPC_HI, OPC_LO: cls = CLS_HI_LO;
      default:       cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  // One-hot {X,V,B,A} destination; only register-loading classes name one
  function automatic logic [3:0] dest_onehot(input cls_e cls, input rsel_e rsel);
    logic [3:0] set;
    if ((cls == CLS_MGET) || (cls == CLS_POP_R)) begin
      set = 4'b0001 << rsel;
    end else begin
      set = 4'b0000;
    end
    return set;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Prefetch FIFO for the decode stage. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter register.
// A push is refused while full even if a pop happens in the same cycle;
// flush empties the FIFO and overrides any push/pop in that cycle.
module instr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  wr_ptr_d;
  logic [AW:0]  rd_ptr_q;
  logic [AW:0]  rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         full_s;
  logic         empty_s;
  logic         do_push_s;
  logic         do_pop_s;

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push_s = push & ~full_s & ~flush;
  assign do_pop_s  = pop & ~empty_s & ~flush;

  assign full  = full_s;
  assign empty = empty_s;
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values: flush clears, otherwise advance on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only observed while the entry is valid
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Buffered SIMP decode stage: fetch words enter a prefetch FIFO over
// valid/ready and the head word is decoded into a registered output slot
// handed to execute over valid/ready.
// Optional build macro ILLEGAL_TRAP_EN: when defined, accepting a CLS_NONE
// word sets a sticky trap that stops the output slot from loading and the
// FIFO from popping until flush or reset. When undefined, illegal words
// pass through as CLS_NONE and trap is tied low.
module instr_decode_stage
  import simp_isa_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INSTR_W-1:0]      in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_cls,
  output logic [3:0]              out_set,
  output logic                    out_les_leq,
  output logic [INSTR_W-5:0]      out_imm,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    trap
);

  logic [INSTR_W-1:0] head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               load_s;
  logic               accept_s;
  logic               illegal_accept_s;
  logic               halt_s;
  cls_e               head_cls_s;

  logic               out_valid_q;
  logic               out_valid_d;
  cls_e               out_cls_q;
  cls_e               out_cls_d;
  logic [3:0]         out_set_q;
  logic [3:0]         out_set_d;
  logic               out_les_leq_q;
  logic               out_les_leq_d;
  logic [INSTR_W-5:0] out_imm_q;
  logic [INSTR_W-5:0] out_imm_d;
  logic [INSTR_W-1:0] out_instr_q;
  logic [INSTR_W-1:0] out_instr_d;

  instr_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (in_valid),
    .pop   (load_s),
    .wdata (in_instr),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign in_ready   = ~fifo_full_s;
  assign accept_s   = out_valid_q & out_ready;
  assign head_cls_s = decode_cls(head_s[INSTR_W-1 -: 4], head_s[INSTR_W-5 -: 2]);

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;
  logic trap_d;

  // An illegal word leaving the slot arms the trap in the same cycle
  assign illegal_accept_s = accept_s & (out_cls_q == CLS_NONE);
  assign halt_s           = trap_q;
  assign trap             = trap_q;

  // Sticky trap: set on illegal accept, cleared only by flush
  always_comb begin
    trap_d = trap_q;
    if (flush) begin
      trap_d = 1'b0;
    end else if (illegal_accept_s) begin
      trap_d = 1'b1;
    end else begin
      trap_d = trap_q;
    end
  end

  // Trap register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
`else
  assign illegal_accept_s = 1'b0;
  assign halt_s           = 1'b0;
  assign trap             = 1'b0;
`endif

  // The slot refills from the FIFO head when it is empty or being consumed;
  // flush and a pending trap both block the refill (and hence the pop)
  assign load_s = ~fifo_empty_s & (~out_valid_q | out_ready) & ~halt_s
                  & ~illegal_accept_s & ~flush;

  // Output slot next state: clear on flush, load decoded head, drop valid on accept
  always_comb begin
    out_valid_d   = out_valid_q;
    out_cls_d     = out_cls_q;
    out_set_d     = out_set_q;
    out_les_leq_d = out_les_leq_q;
    out_imm_d     = out_imm_q;
    out_instr_d   = out_instr_q;
    if (flush) begin
      out_valid_d   = 1'b0;
      out_cls_d     = CLS_NONE;
      out_set_d     = 4'b0000;
      out_les_leq_d = 1'b0;
      out_imm_d     = '0;
      out_instr_d   = '0;
    end else if (load_s) begin
      out_valid_d   = 1'b1;
      out_cls_d     = head_cls_s;
      out_set_d     = dest_onehot(head_cls_s, rsel_e'(head_s[1:0]));
      out_les_leq_d = (head_cls_s == CLS_LES) || (head_cls_s == CLS_LEQ);
      out_imm_d     = head_s[INSTR_W-5:0];
      out_instr_d   = head_s;
    end else if (accept_s) begin
      out_valid_d   = 1'b0;
    end else begin
      out_valid_d   = out_valid_q;
    end
  end

  // Output slot registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_cls_q     <= CLS_NONE;
      out_set_q     <= 4'b0000;
      out_les_leq_q <= 1'b0;
      out_imm_q     <= '0;
      out_instr_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_cls_q     <= out_cls_d;
      out_set_q     <= out_set_d;
      out_les_leq_q <= out_les_leq_d;
      out_imm_q     <= out_imm_d;
      out_instr_q   <= out_instr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_cls     = out_cls_q;
  assign out_set     = out_set_q;
  assign out_les_leq = out_les_leq_q;
  assign out_imm     = out_imm_q;
  assign out_instr   = out_instr_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: an 8-bit instance driven
// through a scoreboard plus a 12-bit instance for width generality.
module tb_instr_decode_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_instr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_cls;
  logic [3:0] out_set;
  logic       out_les_leq;
  logic [3:0] out_imm;
  logic [7:0] out_instr;
  logic [2:0] fifo_count;
  logic       trap;

  logic        w_flush;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [11:0] w_in_instr;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [3:0]  w_out_cls;
  logic [3:0]  w_out_set;
  logic        w_out_les_leq;
  logic [7:0]  w_out_imm;
  logic [11:0] w_out_instr;
  logic [2:0]  w_fifo_count;
  logic        w_trap;

  int n_checks = 0;
  int n_fail   = 0;
  bit drive_timeout = 1'b0;

  typedef struct packed {
    logic [3:0] cls;
    logic [3:0] set;
    logic       ll;
    logic [3:0] imm;
    logic [7:0] instr;
  } exp_t;

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  set;
    logic        ll;
    logic [7:0]  imm;
    logic [11:0] instr;
  } wexp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  wexp_t wq[$];

  instr_decode_stage #(.INSTR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cls(out_cls),
    .out_set(out_set), .out_les_leq(out_les_leq), .out_imm(out_imm),
    .out_instr(out_instr), .fifo_count(fifo_count), .trap(trap)
  );

  instr_decode_stage #(.INSTR_W(12), .DEPTH(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_cls(w_out_cls),
    .out_set(w_out_set), .out_les_leq(w_out_les_leq), .out_imm(w_out_imm),
    .out_instr(w_out_instr), .fifo_count(w_fifo_count), .trap(w_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference class table: NONE0 ADD1 SHIFT_ROT2 NANDI3 ORI4 XORI5 LES6 LEQ7 IGET8 MGET9 POP_R10 HI_LO11
  function automatic logic [3:0] model_cls(input logic [3:0] op, input logic [1:0] sub);
    logic [3:0] c;
    case (op)
      4'b1000: c = 4'd1;
      4'b1010: c = 4'd2;
      4'b1011: c = 4'd3;
      4'b1100: c = 4'd4;
      4'b1101: c = 4'd5;
      4'b1110: c = 4'd6;
      4'b1111: c = 4'd7;
      4'b0100: c = 4'd8;
      4'b0010: c = 4'd9;
      4'b0001: c = (sub == 2'b10) ? 4'd10 : 4'd0;
      4'b0110: c = 4'd11;
      4'b0111: c = 4'd11;
      default: c = 4'd0;
    endcase
    return c;
  endfunction

  function automatic exp_t model8(input logic [7:0] w);
    exp_t e;
    e.cls   = model_cls(w[7:4], w[3:2]);
    e.set   = ((e.cls == 4'd9) || (e.cls == 4'd10)) ? (4'b0001 << w[1:0]) : 4'b0000;
    e.ll    = (e.cls == 4'd6) || (e.cls == 4'd7);
    e.imm   = w[3:0];
    e.instr = w;
    return e;
  endfunction

  // Scoreboard: record accepted input words, compare words accepted by execute
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got instr=%h cls=%0d, expected no output", out_instr, out_cls);
        end else begin
          mon_e = sb.pop_front();
          if (out_cls !== mon_e.cls || out_set !== mon_e.set || out_les_leq !== mon_e.ll ||
              out_imm !== mon_e.imm || out_instr !== mon_e.instr) begin
            n_fail++;
            $display("FAIL sb_compare: got instr=%h cls=%0d set=%b ll=%b imm=%h, expected instr=%h cls=%0d set=%b ll=%b imm=%h",
                     out_instr, out_cls, out_set, out_les_leq, out_imm,
                     mon_e.instr, mon_e.cls, mon_e.set, mon_e.ll, mon_e.imm);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model8(in_instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the handshake edge (bounded)
  task automatic drive_word(input logic [7:0] w);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && g < 64) begin
      tick();
      g++;
    end
    if (!in_ready) drive_timeout = 1'b1;
    else tick();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 8'h00; out_ready = 1'b0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr = 12'h000; w_out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_cls !== 4'd0 || out_set !== 4'd0 || out_imm !== 4'd0 ||
        out_instr !== 8'h00 || out_les_leq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b cls=%0d set=%b imm=%h instr=%h, expected all zero",
               out_valid, out_cls, out_set, out_imm, out_instr);
    end
    n_checks++;
    if (fifo_count !== 3'd0 || in_ready !== 1'b1 || trap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fifo: got count=%0d in_ready=%b trap=%b, expected 0 1 0", fifo_count, in_ready, trap);
    end
    n_checks++;
    if (w_out_valid !== 1'b0 || w_out_instr !== 12'h000 || w_fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_wide: got v=%b instr=%h count=%0d, expected 0 000 0", w_out_valid, w_out_instr, w_fifo_count);
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 8'h21;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL latency_edge_n: got v=%b count=%0d, expected 0 1", out_valid, fifo_count);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_cls !== 4'd9 || out_set !== 4'b0010) begin
      n_fail++;
      $display("FAIL latency_mget: got v=%b cls=%0d set=%b, expected 1 9 0010", out_valid, out_cls, out_set);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_consumed: got v=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [6] = '{8'h81, 8'hA2, 8'hB3, 8'hC4, 8'hD5, 8'hE6};
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_word(words[i]);
    in_valid = 1'b1;
    in_instr = words[5];
    tick();
    tick();
    n_checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got count=%0d in_ready=%b, expected 4 0", fifo_count, in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 8'h81 || out_cls !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_frozen: got v=%b instr=%h cls=%0d, expected 1 81 1", out_valid, out_instr, out_cls);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(ok);
    n_checks++;
    if (!ok || fifo_count !== 3'd0 || drive_timeout) begin
      n_fail++;
      $display("FAIL bp_drain: got drained=%b count=%0d timeout=%b, expected 1 0 0", ok, fifo_count, drive_timeout);
    end
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] spot_w   [4] = '{8'h18, 8'h14, 8'hE0, 8'h6F};
    logic [3:0] spot_cls [4] = '{4'd10, 4'd0, 4'd6, 4'd11};
    logic [3:0] spot_set [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic       spot_ll  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] spot_imm [4] = '{4'h8, 4'h4, 4'h0, 4'hF};
    time t0;
    int  cycles;
    bit  ok;
    out_ready = 1'b1;
    t0 = $time;
    for (int w = 0; w < 256; w++) drive_word(8'(w));
    in_valid = 1'b0;
    cycles = int'(($time - t0) / 10);
    n_checks++;
    if (cycles != 256) begin
      n_fail++;
      $display("FAIL sweep_throughput: got %0d cycles for 256 words, expected 256", cycles);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sweep_drain: got pending=%0d out_valid=%b, expected 0 0", sb.size(), out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive_word(spot_w[i]);
      in_valid = 1'b0;
      for (int g = 0; g < 10; g++) begin
        if (out_valid === 1'b1) break;
        tick();
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_cls !== spot_cls[i] || out_set !== spot_set[i] ||
          out_les_leq !== spot_ll[i] || out_imm !== spot_imm[i]) begin
        n_fail++;
        $display("FAIL spot_%h: got v=%b cls=%0d set=%b ll=%b imm=%h, expected 1 %0d %b %b %h",
                 spot_w[i], out_valid, out_cls, out_set, out_les_leq, out_imm,
                 spot_cls[i], spot_set[i], spot_ll[i], spot_imm[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_word(8'h81 + 8'(i));
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got count=%0d v=%b, expected 3 1", fifo_count, out_valid);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 8'hAA;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_edge: got count=%0d v=%b, expected 0 0", fifo_count, out_valid);
    end
    tick();
    tick();
    n_checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_push: got count=%0d v=%b, expected 0 0", fifo_count, out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_trap();
    bit ok;
    out_ready = 1'b1;
    drive_word(8'h90);
    drive_word(8'h80);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`ifdef ILLEGAL_TRAP_EN
    n_checks++;
    if (trap !== 1'b1 || out_valid !== 1'b0 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL trap_set: got trap=%b v=%b count=%0d, expected 1 0 1", trap, out_valid, fifo_count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (trap !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL trap_flush: got trap=%b count=%0d, expected 0 0", trap, fifo_count);
    end
    drive_word(8'h21);
    in_valid = 1'b0;
`endif
    wait_idle(ok);
    n_checks++;
    if (!ok || trap !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL trap_final: got drained=%b trap=%b count=%0d, expected 1 0 0", ok, trap, fifo_count);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_word(8'h81 + 8'(i));
    in_instr = 8'h85;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got v=%b, expected 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_cls !== 4'd0 || out_instr !== 8'h00 || out_imm !== 4'd0 ||
        out_set !== 4'd0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || trap !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_clear: got v=%b cls=%0d instr=%h count=%0d in_ready=%b, expected 0 0 00 0 1",
               out_valid, out_cls, out_instr, fifo_count, in_ready);
    end
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wide();
    wexp_t      e;
    wexp_t      got;
    logic [11:0] w;
    logic [5:0]  r;
    logic [5:0]  k6;
    w_out_ready = 1'b1;
    w_in_valid  = 1'b1;
    w_in_instr  = 12'h201;
    tick();
    w_in_valid = 1'b0;
    n_checks++;
    if (w_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_latency_n: got v=%b, expected 0", w_out_valid);
    end
    tick();
    n_checks++;
    if (w_out_valid !== 1'b1 || w_out_cls !== 4'd9 || w_out_set !== 4'b0010 || w_out_imm !== 8'h01) begin
      n_fail++;
      $display("FAIL wide_mget: got v=%b cls=%0d set=%b imm=%h, expected 1 9 0010 01",
               w_out_valid, w_out_cls, w_out_set, w_out_imm);
    end
    tick();
    for (int k = 0; k < 64; k++) begin
      r  = 6'($urandom_range(0, 63));
      k6 = 6'(k);
      w  = {k6, r};
      e.cls   = model_cls(w[11:8], w[7:6]);
      e.set   = ((e.cls == 4'd9) || (e.cls == 4'd10)) ? (4'b0001 << w[1:0]) : 4'b0000;
      e.ll    = (e.cls == 4'd6) || (e.cls == 4'd7);
      e.imm   = w[7:0];
      e.instr = w;
      wq.push_back(e);
      w_in_valid = 1'b1;
      w_in_instr = w;
      tick();
      w_in_valid = 1'b0;
      for (int g = 0; g < 10; g++) begin
        if (w_out_valid === 1'b1) break;
        tick();
      end
      n_checks++;
      if (w_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wide_timeout: word %h got no out_valid, expected 1", w);
        wq.delete();
      end else begin
        got = wq.pop_front();
        if (w_out_cls !== got.cls || w_out_set !== got.set || w_out_les_leq !== got.ll ||
            w_out_imm !== got.imm || w_out_instr !== got.instr) begin
          n_fail++;
          $display("FAIL wide_compare: got instr=%h cls=%0d set=%b ll=%b imm=%h, expected instr=%h cls=%0d set=%b ll=%b imm=%h",
                   w_out_instr, w_out_cls, w_out_set, w_out_les_leq, w_out_imm,
                   got.instr, got.cls, got.set, got.ll, got.imm);
        end
      end
      tick();
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_latency();
    test_backpressure();
    test_opcode_sweep();
    test_flush();
    test_trap();
    test_async_reset();
    test_reset();
    test_wide();
    n_checks++;
    if (drive_timeout) begin
      n_fail++;
      $display("FAIL drive_timeout: got in_ready stuck low, expected handshake");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the run never reaches its summary
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
